instruction_fetch: RTL and testbench

//  IF stage of the pipelined MIPS datapath; sole producer for the IF_ID register.

---
 rtl/instruction_fetch.sv | 104 ++++++++++
 tb/tb_instruction_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, instruction memory with a debug
// program-load port, branch/jump redirect and stall handling, and the
// IDLE/RUN/HALT execution control FSM.
module instruction_fetch #(
  parameter int PC_BITS          = 32,
  parameter int INSTRUCTION_BITS = 32,
  parameter int MEM_ADDR_BITS    = 10,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_INSTR = {INSTRUCTION_BITS{1'b1}}
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        i_pc_write,
  input  logic                        i_branch_taken,
  input  logic [PC_BITS-1:0]          i_branch_target,
  input  logic                        i_jump,
  input  logic [PC_BITS-1:0]          i_jump_target,
  input  logic                        i_start,
  input  logic                        i_load_en,
  input  logic [MEM_ADDR_BITS-1:0]    i_load_addr,
  input  logic [INSTRUCTION_BITS-1:0] i_load_data,
  output logic [PC_BITS-1:0]          o_pc,
  output logic [PC_BITS-1:0]          o_PCNext,
  output logic [INSTRUCTION_BITS-1:0] o_instruction,
  output logic                        o_running,
  output logic                        o_halted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam int                 MEM_WORDS = 2 ** MEM_ADDR_BITS;
  localparam logic [PC_BITS-1:0] PC_ONE    = {{(PC_BITS-1){1'b0}}, 1'b1};

  state_t                      r_state, w_state_next;
  logic [PC_BITS-1:0]          r_pc, w_pc_next;
  logic [INSTRUCTION_BITS-1:0] r_mem [MEM_WORDS];
  logic                        w_in_range;
  logic [INSTRUCTION_BITS-1:0] w_mem_rd;

  // PCs beyond the memory depth fetch a NOP rather than aliasing.
  assign w_in_range    = (r_pc[PC_BITS-1:MEM_ADDR_BITS] == '0);
  assign w_mem_rd      = w_in_range ? r_mem[r_pc[MEM_ADDR_BITS-1:0]] : '0;
  assign o_instruction = (r_state == S_RUN) ? w_mem_rd : '0;
  assign o_pc          = r_pc;
  assign o_PCNext      = r_pc + PC_ONE;
  assign o_running     = (r_state == S_RUN);
  assign o_halted      = (r_state == S_HALT);

  // Program load: only while not executing, regardless of enable; never reset.
  always_ff @(posedge clk) begin
    if (i_load_en && (r_state != S_RUN))
      r_mem[i_load_addr] <= i_load_data;
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next state / next PC. Redirects beat stalls, stalls beat the halt check,
  // so a halt fetched on a wrong path or while stalled never takes effect.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (enable) begin
      case (r_state)
        S_IDLE: begin
          w_pc_next = '0;
          if (i_start) w_state_next = S_RUN;
        end
        S_RUN: begin
          if (i_branch_taken)                  w_pc_next = i_branch_target;
          else if (i_jump)                     w_pc_next = i_jump_target;
          else if (!i_pc_write)                w_pc_next = r_pc;
          else if (o_instruction == HALT_INSTR) w_state_next = S_HALT;
          else                                 w_pc_next = r_pc + PC_ONE;
        end
        S_HALT: begin
          if (i_branch_taken) begin
            w_pc_next    = i_branch_target;
            w_state_next = S_RUN;
          end else if (i_jump) begin
            w_pc_next    = i_jump_target;
            w_state_next = S_RUN;
          end else if (i_start) begin
            w_pc_next    = '0;
            w_state_next = S_RUN;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_pc_next    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run, all compared against a word-level behavioural model.
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] IA = 32'h1111_0001, IB = 32'h2222_0002, IC = 32'h3333_0003;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic        i_pc_write = 1'b1, i_branch_taken = 1'b0, i_jump = 1'b0;
  logic        i_start = 1'b0, i_load_en = 1'b0;
  logic [31:0] i_branch_target = '0, i_jump_target = '0, i_load_data = '0;
  logic [9:0]  i_load_addr = '0;
  logic [31:0] o_pc, o_PCNext, o_instruction;
  logic        o_running, o_halted;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .enable(enable), .i_pc_write(i_pc_write),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_jump(i_jump), .i_jump_target(i_jump_target), .i_start(i_start),
    .i_load_en(i_load_en), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
    .o_pc(o_pc), .o_PCNext(o_PCNext), .o_instruction(o_instruction),
    .o_running(o_running), .o_halted(o_halted));

  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = running, 2 = halted.
  logic [31:0] m_mem [1024];
  int          m_st = 0;
  logic [31:0] m_pc = '0;
  int          nchk = 0, nerr = 0;

  function automatic logic [31:0] m_instr();
    if (m_st != 1 || m_pc >= 32'd1024) return '0;
    return m_mem[m_pc[9:0]];
  endfunction

  function automatic logic [97:0] obs();
    return {o_pc, o_PCNext, o_instruction, o_running, o_halted};
  endfunction

  function automatic logic [97:0] expv();
    return {m_pc, m_pc + 32'd1, m_instr(), m_st == 1, m_st == 2};
  endfunction

  // One clock edge: model decides from pre-edge state and inputs.
  task automatic tick();
    int          n_st = m_st;
    logic [31:0] n_pc = m_pc;
    logic [31:0] ins  = m_instr();
    if (enable) begin
      if (m_st == 0) begin
        n_pc = '0;
        if (i_start) n_st = 1;
      end else if (m_st == 1) begin
        if (i_branch_taken)   n_pc = i_branch_target;
        else if (i_jump)      n_pc = i_jump_target;
        else if (!i_pc_write) n_pc = m_pc;
        else if (ins == HALT) n_st = 2;
        else                  n_pc = m_pc + 32'd1;
      end else begin
        if (i_branch_taken)   begin n_pc = i_branch_target; n_st = 1; end
        else if (i_jump)      begin n_pc = i_jump_target;   n_st = 1; end
        else if (i_start)     begin n_pc = '0;              n_st = 1; end
      end
    end
    @(posedge clk);
    if (i_load_en && m_st != 1) m_mem[i_load_addr] = i_load_data;
    m_st = n_st;
    m_pc = n_pc;
    #1;
  endtask

  task automatic idle_inputs();
    i_pc_write = 1'b1; i_branch_taken = 1'b0; i_jump = 1'b0;
    i_start = 1'b0; i_load_en = 1'b0; enable = 1'b1;
  endtask

  task automatic jump_to(input logic [31:0] t);
    i_jump = 1'b1; i_jump_target = t;
    tick();
    i_jump = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    nchk++;
    if (obs() !== {32'd0, 32'd1, 32'd0, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL reset got %h exp %h", obs(), {32'd0, 32'd1, 32'd0, 2'b00});
    end
    rst = 1'b0;
  endtask

  task automatic fill_mem();
    i_load_en = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      i_load_addr = a[9:0];
      case (a)
        0: i_load_data = IA;
        1: i_load_data = IB;
        2: i_load_data = IC;
        3, 7: i_load_data = HALT;
        default: i_load_data = $urandom & 32'h7FFF_FFFF;
      endcase
      tick();
    end
    i_load_en = 1'b0;
    nchk++;
    if (obs() !== expv()) begin nerr++; $display("FAIL load_idle got %h exp %h", obs(), expv()); end
  endtask

  task automatic test_program();
    logic [31:0] want [4];
    want[0] = IA; want[1] = IB; want[2] = IC; want[3] = HALT;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nchk++;
      if (o_pc !== k || o_PCNext !== k + 1 || o_instruction !== want[k] || o_running !== 1'b1) begin
        nerr++; $display("FAIL program_pc%0d got pc %0d next %0d ins %h exp pc %0d next %0d ins %h",
                         k, o_pc, o_PCNext, o_instruction, k, k + 1, want[k]);
      end
      if (k < 3) tick();
    end
    tick();
    nchk++;
    if (o_halted !== 1'b1 || o_running !== 1'b0 || o_pc !== 32'd3 || o_instruction !== 32'd0) begin
      nerr++; $display("FAIL program_halt got halted %b pc %0d ins %h exp halted 1 pc 3 ins 0",
                       o_halted, o_pc, o_instruction);
    end
    tick();
    nchk++;
    if (obs() !== expv()) begin nerr++; $display("FAIL halt_hold got %h exp %h", obs(), expv()); end
  endtask

  task automatic test_stall();
    jump_to(32'd5);
    i_pc_write = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      nchk++;
      if (o_pc !== 32'd5 || o_instruction !== m_mem[5] || o_running !== 1'b1) begin
        nerr++; $display("FAIL stall%0d got pc %0d ins %h exp pc 5 ins %h", k, o_pc, o_instruction, m_mem[5]);
      end
    end
    i_pc_write = 1'b1; tick();
    nchk++;
    if (o_pc !== 32'd6) begin nerr++; $display("FAIL stall_release got pc %0d exp 6", o_pc); end
  endtask

  task automatic test_priority();
    i_branch_taken = 1'b1; i_branch_target = 32'd20;
    i_jump = 1'b1; i_jump_target = 32'd40; i_pc_write = 1'b0;
    tick();
    idle_inputs();
    nchk++;
    if (o_pc !== 32'd20) begin nerr++; $display("FAIL priority got pc %0d exp 20", o_pc); end
    i_jump = 1'b1; i_jump_target = 32'd40; i_pc_write = 1'b0;
    tick();
    idle_inputs();
    nchk++;
    if (o_pc !== 32'd40) begin nerr++; $display("FAIL jump_over_stall got pc %0d exp 40", o_pc); end
  endtask

  task automatic test_halt_redirect();
    jump_to(32'd7);
    jump_to(32'd9);
    nchk++;
    if (o_pc !== 32'd9 || o_running !== 1'b1 || o_halted !== 1'b0) begin
      nerr++; $display("FAIL halt_redirect got pc %0d run %b halt %b exp pc 9 run 1 halt 0",
                       o_pc, o_running, o_halted);
    end
  endtask

  task automatic test_boundary();
    i_pc_write = 1'b0; i_load_en = 1'b1; i_load_addr = 10'd0; i_load_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    jump_to(32'd0);
    nchk++;
    if (o_instruction !== IA) begin nerr++; $display("FAIL load_in_run got ins %h exp %h", o_instruction, IA); end
    jump_to(32'd1024);
    nchk++;
    if (o_instruction !== 32'd0 || o_running !== 1'b1) begin
      nerr++; $display("FAIL out_of_range got ins %h run %b exp ins 0 run 1", o_instruction, o_running);
    end
    jump_to(32'hFFFF_FFFF);
    nchk++;
    if (o_PCNext !== 32'd0) begin nerr++; $display("FAIL pcnext_wrap got %h exp 0", o_PCNext); end
    tick();
    nchk++;
    if (o_pc !== 32'd0 || o_instruction !== IA) begin
      nerr++; $display("FAIL pc_wrap got pc %h ins %h exp pc 0 ins %h", o_pc, o_instruction, IA);
    end
  endtask

  task automatic test_enable();
    logic [31:0] held = o_pc;
    enable = 1'b0; i_jump = 1'b1; i_jump_target = 32'd50; i_start = 1'b1;
    tick(); tick();
    idle_inputs();
    nchk++;
    if (o_pc !== held || o_running !== 1'b1) begin
      nerr++; $display("FAIL enable_hold got pc %0d run %b exp pc %0d run 1", o_pc, o_running, held);
    end
  endtask

  task automatic test_async_reset();
    jump_to(32'd12);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m_st = 0; m_pc = '0;
    nchk++;
    if (obs() !== {32'd0, 32'd1, 32'd0, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL async_reset got %h exp %h", obs(), {32'd0, 32'd1, 32'd0, 2'b00});
    end
    #1 rst = 1'b0;
    enable = 1'b0; i_start = 1'b1; tick();
    nchk++;
    if (o_running !== 1'b0) begin nerr++; $display("FAIL start_disabled got run %b exp 0", o_running); end
    enable = 1'b1; tick(); i_start = 1'b0;
    nchk++;
    if (o_pc !== 32'd0 || o_instruction !== IA || o_running !== 1'b1) begin
      nerr++; $display("FAIL restart got pc %0d ins %h exp pc 0 ins %h", o_pc, o_instruction, IA);
    end
    tick();
    nchk++;
    if (o_pc !== 32'd1 || o_instruction !== IB) begin
      nerr++; $display("FAIL restart_next got pc %0d ins %h exp pc 1 ins %h", o_pc, o_instruction, IB);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      enable          = ($urandom_range(0, 9) != 0);
      i_pc_write      = ($urandom_range(0, 4) != 0);
      i_branch_taken  = ($urandom_range(0, 9) == 0);
      i_branch_target = $urandom_range(0, 1100);
      i_jump          = ($urandom_range(0, 9) == 0);
      i_jump_target   = $urandom_range(0, 1100);
      i_start         = ($urandom_range(0, 7) == 0);
      i_load_en       = ($urandom_range(0, 2) == 0);
      i_load_addr     = 10'($urandom_range(0, 1023));
      i_load_data     = ($urandom_range(0, 5) == 0) ? HALT : ($urandom & 32'h7FFF_FFFF);
      tick();
      nchk++;
      if (obs() !== expv()) begin nerr++; $display("FAIL random%0d got %h exp %h", n, obs(), expv()); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    fill_mem();
    test_program();
    test_stall();
    test_priority();
    test_halt_redirect();
    test_boundary();
    test_enable();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
